// File: rtl/inst_fetch_pkg.sv
// Shared types and widths for the byte-serial instruction fetch unit.
// Optional instruction cache is built only when ICACHE_EN is defined.
package inst_fetch_pkg;

   localparam int unsigned InstAddrW = 32;
   localparam int unsigned RegW      = 32;
   localparam int unsigned MemDataW  = 8;

   typedef enum logic [1:0] {
      StLookup = 2'd0,
      StFetch  = 2'd1,
      StHold   = 2'd2
   } fetch_state_e;

   function automatic logic [InstAddrW-1:0] word_align(input logic [InstAddrW-1:0] addr);
      return {addr[InstAddrW-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch unit bus bundle: byte RAM port, branch redirect and the if_id handshake.
// Unaffected by ICACHE_EN.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic [InstAddrW-1:0] mem_a;
   logic                 mem_rd;
   logic [MemDataW-1:0]  mem_din;
   logic                 mem_busy;
   logic                 br_flag;
   logic [InstAddrW-1:0] br_target;
   logic                 if_ready;
   logic                 if_valid;
   logic [RegW-1:0]      if_inst;
   logic [InstAddrW-1:0] if_pc;

   modport master (
      output mem_a, mem_rd, if_valid, if_inst, if_pc,
      input  mem_din, mem_busy, br_flag, br_target, if_ready
   );

   modport slave (
      input  mem_a, mem_rd, if_valid, if_inst, if_pc,
      output mem_din, mem_busy, br_flag, br_target, if_ready
   );

endinterface

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, combinational hit; compiled only under ICACHE_EN.
// Ports carry word addresses (byte address bits [1:0] already dropped).
`ifdef ICACHE_EN
module inst_fetch_icache
   import inst_fetch_pkg::*;
#(
   parameter int unsigned IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [InstAddrW-3:0] rd_word_i,
   output logic                 rd_hit_o,
   output logic [RegW-1:0]      rd_data_o,
   input  logic                 wr_en_i,
   input  logic [InstAddrW-3:0] wr_word_i,
   input  logic [RegW-1:0]      wr_data_i
);

   localparam int unsigned Entries = 1 << IDX_W;
   localparam int unsigned TagW    = InstAddrW - 2 - IDX_W;

   logic [RegW-1:0]    data_q [Entries];
   logic [TagW-1:0]    tag_q  [Entries];
   logic [Entries-1:0] valid_q, valid_d;
   logic [IDX_W-1:0]   rd_idx, wr_idx;

   assign rd_idx    = rd_word_i[IDX_W-1:0];
   assign wr_idx    = wr_word_i[IDX_W-1:0];
   assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_word_i[InstAddrW-3:IDX_W]);
   assign rd_data_o = data_q[rd_idx];

   always_comb begin
      valid_d = valid_q;
      if (wr_en_i) valid_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   // Payload needs no reset: a line is only read once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         data_q[wr_idx] <= wr_data_i;
         tag_q[wr_idx]  <= wr_word_i[InstAddrW-3:IDX_W];
      end
   end

endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles 32-bit little-endian words from a shared 8-bit RAM.
// Define ICACHE_EN to add a direct-mapped instruction cache in front of the RAM.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [InstAddrW-1:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned          ICACHE_IDX_W = 5
) (
   input logic          clk,
   input logic          rst,
   inst_fetch_if.master bus
);

   if (ICACHE_IDX_W == 0 || ICACHE_IDX_W > 28) begin : g_bad_idx_w
      $error("ICACHE_IDX_W out of range");
   end

   fetch_state_e                state_q, state_d;
   logic [InstAddrW-1:0]        pc_q, pc_d;
   logic [2:0]                  cnt_q, cnt_d;
   logic                        iss_q, iss_d;
   logic [2:0][MemDataW-1:0]    byte_q, byte_d;
   logic                        if_valid_q, if_valid_d;
   logic [RegW-1:0]             if_inst_q, if_inst_d;
   logic [InstAddrW-1:0]        if_pc_q, if_pc_d;
   logic [InstAddrW-1:0]        mem_a_q, mem_a;
   logic                        issue;
   logic [1:0]                  slot;
   logic [RegW-1:0]             fetched;

   // A redirect or reset in this cycle suppresses the read; its byte would be thrown away.
   assign issue   = (state_q == StFetch) && (cnt_q < 3'd4) && !bus.mem_busy &&
                    !bus.br_flag && !rst;
   assign slot    = 2'(cnt_q - 3'd1);
   assign fetched = {bus.mem_din, byte_q[2], byte_q[1], byte_q[0]};

`ifdef ICACHE_EN
   logic            hit;
   logic [RegW-1:0] hit_inst;
   logic            fill;

   assign fill = (state_q == StFetch) && (cnt_q == 3'd4) && !bus.br_flag;

   inst_fetch_icache #(
      .IDX_W (ICACHE_IDX_W)
   ) u_icache (
      .clk       (clk),
      .rst       (rst),
      .rd_word_i (pc_q[InstAddrW-1:2]),
      .rd_hit_o  (hit),
      .rd_data_o (hit_inst),
      .wr_en_i   (fill),
      .wr_word_i (pc_q[InstAddrW-1:2]),
      .wr_data_i (fetched)
   );
`endif

   always_comb begin
      mem_a = mem_a_q;
      if (issue) mem_a = pc_q + 32'(cnt_q);
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      iss_d      = 1'b0;
      byte_d     = byte_q;
      if_valid_d = if_valid_q;
      if_inst_d  = if_inst_q;
      if_pc_d    = if_pc_q;

      // The byte for the address issued last cycle is on mem_din now, busy or not.
      if (iss_q) begin
         unique case (slot)
            2'd0:    byte_d[0] = bus.mem_din;
            2'd1:    byte_d[1] = bus.mem_din;
            2'd2:    byte_d[2] = bus.mem_din;
            default: ;
         endcase
      end

      unique case (state_q)
         StLookup: begin
`ifdef ICACHE_EN
            if (hit) begin
               state_d    = StHold;
               if_valid_d = 1'b1;
               if_inst_d  = hit_inst;
               if_pc_d    = pc_q;
            end else begin
               state_d = StFetch;
               cnt_d   = 3'd0;
            end
`else
            state_d = StFetch;
            cnt_d   = 3'd0;
`endif
         end
         StFetch: begin
            if (issue) begin
               cnt_d = cnt_q + 3'd1;
               iss_d = 1'b1;
            end
            // cnt reaches 4 only right after byte 3 was issued, so byte 3 is on mem_din now.
            if (cnt_q == 3'd4) begin
               state_d    = StHold;
               if_valid_d = 1'b1;
               if_inst_d  = fetched;
               if_pc_d    = pc_q;
            end
         end
         StHold: begin
            if (bus.if_ready) begin
               pc_d       = pc_q + 32'd4;
               if_valid_d = 1'b0;
               state_d    = StLookup;
            end
         end
         default: state_d = StLookup;
      endcase

      if (bus.br_flag) begin
         state_d    = StLookup;
         pc_d       = word_align(bus.br_target);
         cnt_d      = 3'd0;
         iss_d      = 1'b0;
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StLookup;
         pc_q       <= RESET_PC;
         cnt_q      <= 3'd0;
         iss_q      <= 1'b0;
         byte_q     <= '0;
         if_valid_q <= 1'b0;
         if_inst_q  <= '0;
         if_pc_q    <= '0;
         mem_a_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         iss_q      <= iss_d;
         byte_q     <= byte_d;
         if_valid_q <= if_valid_d;
         if_inst_q  <= if_inst_d;
         if_pc_q    <= if_pc_d;
         mem_a_q    <= mem_a;
      end
   end

   assign bus.mem_a    = mem_a;
   assign bus.mem_rd   = issue;
   assign bus.if_valid = if_valid_q;
   assign bus.if_inst  = if_inst_q;
   assign bus.if_pc    = if_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch with a byte RAM model and a word-level fetch model.
// The cache scenario runs only when ICACHE_EN is defined.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam logic [31:0] ResetPc = 32'h0000_0000;

   logic       clk = 1'b0;
   logic       rst;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] ram [4096];

   inst_fetch_if bus ();

   inst_fetch #(
      .RESET_PC     (ResetPc),
      .ICACHE_IDX_W (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Byte returned one cycle after a read; junk when the port was not read.
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_din <= ram[bus.mem_a[11:0]];
      else            bus.mem_din <= 8'($urandom);
   end

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      logic [11:0] a;
      a = addr[11:0];
      return {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.mem_busy = 1'b0;
      bus.br_flag = 1'b0;
      bus.br_target = '0;
      bus.if_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (bus.if_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid=%b rd=%b expected 0 0", bus.if_valid, bus.mem_rd);
      end
      n_checks++;
      if (bus.if_inst !== 32'h0 || bus.if_pc !== 32'h0 || bus.mem_a !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: inst=%h pc=%h a=%h expected zeros",
                  bus.if_inst, bus.if_pc, bus.mem_a);
      end
      rst = 1'b0;
      @(negedge clk); // first FETCH cycle
      #1;
      n_checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_a !== ResetPc) begin
         n_fail++;
         $display("FAIL reset_first_issue: rd=%b a=%h expected 1 %h", bus.mem_rd, bus.mem_a,
                  ResetPc);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; // fetch in progress, cnt=2
      #1;
      n_checks++;
      if (bus.mem_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midfetch_rd: got %b expected 0", bus.mem_rd);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_rd !== 1'b0 || bus.if_valid !== 1'b0 || bus.mem_a !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_after_abort: rd=%b valid=%b a=%h expected 0 0 0",
                  bus.mem_rd, bus.if_valid, bus.mem_a);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_a !== ResetPc) begin
         n_fail++;
         $display("FAIL reset_restart: rd=%b a=%h expected 1 %h", bus.mem_rd, bus.mem_a, ResetPc);
      end
   endtask

   // Records issued addresses/cycles and the first valid cycle over a fixed window.
   task automatic test_first_fetch();
      int          iss_c[$];
      logic [31:0] iss_a[$];
      int          vc = -1;
      ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'hA0; ram[3] = 8'h00;
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (bus.mem_rd) begin
            iss_c.push_back(c);
            iss_a.push_back(bus.mem_a);
         end
         if (bus.if_valid && vc < 0) vc = c;
      end
      n_checks++;
      if (iss_a.size() != 4) begin
         n_fail++;
         $display("FAIL first_issue_count: got %0d expected 4", iss_a.size());
      end
      for (int k = 0; k < 4 && k < iss_a.size(); k++) begin
         n_checks++;
         if (iss_a[k] !== 32'(k) || iss_c[k] != iss_c[0] + k) begin
            n_fail++;
            $display("FAIL first_issue_%0d: addr=%h cycle=%0d expected %h %0d", k, iss_a[k],
                     iss_c[k], 32'(k), iss_c[0] + k);
         end
      end
      n_checks++;
      if (iss_c.size() == 0 || vc < 0 || vc - iss_c[0] != 5) begin
         n_fail++;
         $display("FAIL first_latency: valid cycle %0d expected 5 after first issue", vc);
      end
      n_checks++;
      if (bus.if_inst !== 32'h00A0_0513 || bus.if_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL first_inst: inst=%h pc=%h expected 00a00513 00000000",
                  bus.if_inst, bus.if_pc);
      end
   endtask

   task automatic test_hold_stall();
      bit          seen_iss = 0;
      logic [31:0] first_iss = '1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h00A0_0513 || bus.if_pc !== 32'h0 ||
             bus.mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable_%0d: valid=%b inst=%h pc=%h rd=%b expected 1 00a00513 0 0",
                     c, bus.if_valid, bus.if_inst, bus.if_pc, bus.mem_rd);
         end
      end
      @(negedge clk);
      bus.if_ready = 1'b1;
      @(negedge clk);
      bus.if_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.if_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_valid_clear: got %b expected 0", bus.if_valid);
      end
      for (int c = 0; c < 10 && !seen_iss; c++) begin
         @(negedge clk);
         #1;
         if (bus.mem_rd) begin
            seen_iss = 1;
            first_iss = bus.mem_a;
         end
      end
      n_checks++;
      if (!seen_iss || first_iss !== 32'h4) begin
         n_fail++;
         $display("FAIL hold_next_fetch: issued=%b addr=%h expected 1 00000004", seen_iss,
                  first_iss);
      end
   endtask

   task automatic test_busy();
      int          iss_c[$];
      logic [31:0] iss_a[$];
      int          vc = -1;
      for (int k = 0; k < 4; k++) ram[k] = 8'($urandom);
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         bus.mem_busy = (c == 3); // cycle in which pc+2 is due
         #1;
         if (bus.mem_rd) begin
            iss_c.push_back(c);
            iss_a.push_back(bus.mem_a);
         end
         if (bus.if_valid && vc < 0) vc = c;
      end
      bus.mem_busy = 1'b0;
      n_checks++;
      if (iss_a.size() != 4 || iss_c.size() != 4) begin
         n_fail++;
         $display("FAIL busy_issue_count: got %0d expected 4", iss_a.size());
      end else begin
         n_checks++;
         if (iss_a[2] !== 32'h2 || iss_c[2] - iss_c[1] != 2 || iss_c[3] - iss_c[2] != 1) begin
            n_fail++;
            $display("FAIL busy_stall: addr2=%h gaps=%0d,%0d expected 2 2,1", iss_a[2],
                     iss_c[2] - iss_c[1], iss_c[3] - iss_c[2]);
         end
         n_checks++;
         if (vc < 0 || vc - iss_c[0] != 6) begin
            n_fail++;
            $display("FAIL busy_latency: got %0d expected 6", vc - iss_c[0]);
         end
      end
      n_checks++;
      if (bus.if_inst !== word_at(32'h0) || bus.if_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL busy_inst: inst=%h pc=%h expected %h 0", bus.if_inst, bus.if_pc,
                  word_at(32'h0));
      end
   endtask

   task automatic test_branch();
      bit          seen_iss = 0;
      logic [31:0] first_iss = '1;
      int          n_valid = 0;
      for (int k = 0; k < 4; k++) ram[12'h100 + k] = ~ram[k];
      apply_reset();
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         bus.br_flag = (c == 3); // cnt=2
         bus.br_target = 32'h100;
         #1;
         if (c > 3 && bus.mem_rd && !seen_iss) begin
            seen_iss = 1;
            first_iss = bus.mem_a;
         end
         if (bus.if_valid) begin
            n_valid++;
            n_checks++;
            if (bus.if_inst !== word_at(32'h100) || bus.if_pc !== 32'h100) begin
               n_fail++;
               $display("FAIL branch_inst: inst=%h pc=%h expected %h 00000100", bus.if_inst,
                        bus.if_pc, word_at(32'h100));
            end
         end
      end
      bus.br_flag = 1'b0;
      n_checks++;
      if (!seen_iss || first_iss !== 32'h100 || n_valid == 0) begin
         n_fail++;
         $display("FAIL branch_redirect: addr=%h valids=%0d expected 00000100 >0", first_iss,
                  n_valid);
      end
   endtask

   task automatic test_br_handshake();
      bit          got_valid = 0;
      bit          seen_iss = 0;
      logic [31:0] first_iss = '1;
      apply_reset();
      for (int c = 0; c < 20 && !got_valid; c++) begin
         @(negedge clk);
         #1;
         got_valid = bus.if_valid;
      end
      n_checks++;
      if (!got_valid) begin
         n_fail++;
         $display("FAIL brhs_first_valid: got 0 expected 1");
      end
      bus.if_ready = 1'b1;
      bus.br_flag = 1'b1;
      bus.br_target = 32'h20B;
      @(negedge clk);
      bus.if_ready = 1'b0;
      bus.br_flag = 1'b0;
      got_valid = 0;
      for (int c = 0; c < 20 && !got_valid; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (bus.mem_rd && !seen_iss) begin
            seen_iss = 1;
            first_iss = bus.mem_a;
         end
         got_valid = bus.if_valid;
      end
      n_checks++;
      if (!seen_iss || first_iss !== 32'h208) begin
         n_fail++;
         $display("FAIL brhs_issue: addr=%h expected 00000208", first_iss);
      end
      n_checks++;
      if (!got_valid || bus.if_pc !== 32'h208 || bus.if_inst !== word_at(32'h208)) begin
         n_fail++;
         $display("FAIL brhs_target: valid=%b pc=%h inst=%h expected 1 00000208 %h", got_valid,
                  bus.if_pc, bus.if_inst, word_at(32'h208));
      end
   endtask

   // Word-level model: sequential pc, +4 on each accepted word, redirect wins over accept.
   task automatic test_random();
      logic [31:0] exp_pc = ResetPc;
      logic [31:0] tgt;
      int          k = 0;
      int          n_hs = 0;
      bit          br;
      bit          rdy;
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c > 0) @(negedge clk);
         br = 0;
         tgt = '0;
         if (c == 5) begin
            br = 1;
            tgt = 32'hFFFF_FFFE;
         end else if (n_hs >= 3 && $urandom_range(0, 39) == 0) begin
            br = 1;
            tgt = $urandom;
         end
         rdy = ($urandom_range(0, 2) == 0);
         bus.mem_busy = ($urandom_range(0, 3) == 0);
         bus.if_ready = rdy;
         bus.br_flag = br;
         bus.br_target = tgt;
         #1;
         if (br) begin
            exp_pc = tgt & 32'hFFFF_FFFC;
            k = 0;
         end else begin
            if (bus.mem_rd) begin
               n_checks++;
               if (k >= 4 || bus.mem_a !== exp_pc + 32'(k)) begin
                  n_fail++;
                  $display("FAIL rand_issue c=%0d: addr=%h expected %h (byte %0d)", c,
                           bus.mem_a, exp_pc + 32'(k), k);
               end
               k++;
            end
            if (bus.if_valid && rdy) begin
               n_checks++;
               if (bus.if_pc !== exp_pc || bus.if_inst !== word_at(exp_pc)) begin
                  n_fail++;
                  $display("FAIL rand_accept c=%0d: pc=%h inst=%h expected %h %h", c,
                           bus.if_pc, bus.if_inst, exp_pc, word_at(exp_pc));
               end
               exp_pc = exp_pc + 32'd4;
               k = 0;
               n_hs++;
            end
         end
      end
      bus.mem_busy = 1'b0;
      bus.if_ready = 1'b0;
      bus.br_flag = 1'b0;
      n_checks++;
      if (n_hs < 50) begin
         n_fail++;
         $display("FAIL rand_progress: accepted %0d expected >= 50", n_hs);
      end
   endtask

`ifdef ICACHE_EN
   task automatic test_icache();
      bit          pass2 = 0;
      int          last_ev = 0;
      int          rd2 = 0;
      int          hs2 = 0;
      logic [31:0] exp_pc = 32'h0;
      bit          br;
      apply_reset();
      for (int c = 0; c < 100 && hs2 < 3; c++) begin
         if (c > 0) @(negedge clk);
         br = !pass2 && bus.if_valid && (bus.if_pc == 32'h8);
         bus.if_ready = 1'b1;
         bus.br_flag = br;
         bus.br_target = 32'h0;
         #1;
         if (pass2 && bus.mem_rd) rd2++;
         if (br) begin
            pass2 = 1;
            last_ev = c;
         end else if (pass2 && bus.if_valid) begin
            n_checks++;
            if (bus.if_pc !== exp_pc || bus.if_inst !== word_at(exp_pc) || c - last_ev != 2) begin
               n_fail++;
               $display("FAIL icache_hit: pc=%h inst=%h lat=%0d expected %h %h 2", bus.if_pc,
                        bus.if_inst, c - last_ev, exp_pc, word_at(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            last_ev = c;
            hs2++;
         end
      end
      bus.if_ready = 1'b0;
      bus.br_flag = 1'b0;
      n_checks++;
      if (hs2 != 3 || rd2 != 0) begin
         n_fail++;
         $display("FAIL icache_loop: hits=%0d reads=%0d expected 3 0", hs2, rd2);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.mem_busy = 1'b0;
      bus.br_flag = 1'b0;
      bus.br_target = '0;
      bus.if_ready = 1'b0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
      test_reset();
      test_first_fetch();
      test_hold_stall();
      test_busy();
      test_branch();
      test_br_handshake();
      test_random();
`ifdef ICACHE_EN
      test_icache();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
